// File: rtl/monolith_bricks_if.sv
// Handshake and state-vector bundle between a Monolith round controller and the bricks layer.
interface monolith_bricks_if #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
);
  logic                  start;
  logic [WORD_WIDTH-1:0] state_in  [STATE_SIZE];
  logic [WORD_WIDTH-1:0] state_out [STATE_SIZE];
  logic                  valid;
  logic                  busy;

  modport master (
    output start, state_in,
    input  state_out, valid, busy
  );

  modport slave (
    input  start, state_in,
    output state_out, valid, busy
  );
endinterface

// File: rtl/monolith_bricks.sv
// Monolith bricks layer over GF(2^31-1): y0 = x0, yi = xi + x(i-1)^2, one shared squarer, lanes serial.
// Define MONOLITH_BRICKS_PIPE_EN to register the 62-bit product before reduction (one extra cycle).
module monolith_bricks #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
) (
  input  logic             clk,
  input  logic             reset,
  monolith_bricks_if.slave bus
);

  localparam int W  = WORD_WIDTH;
  localparam int LW = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam int CW = $clog2(STATE_SIZE + 2);
`ifdef MONOLITH_BRICKS_PIPE_EN
  localparam int LAST = STATE_SIZE + 1;
`else
  localparam int LAST = STATE_SIZE;
`endif
  localparam logic [W-1:0] P = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, issue;
  logic [W-1:0]    x_r [STATE_SIZE];
  logic [W-1:0]    y_r [STATE_SIZE];
  logic [LW-1:0]   lane;
  logic [W-1:0]    x_prev;
  logic [2*W-1:0]  prod;
  logic            wr_en;
  logic [LW-1:0]   wr_idx;
  logic [2*W-1:0]  wr_prod;
  logic [W-1:0]    wr_cur;

  // hi + lo folds 2^31 to 1; a second fold absorbs the carry, leaving [0, p] with p aliasing 0.
  function automatic logic [W-1:0] mersenne_reduce(input logic [2*W-1:0] v);
    logic [W:0] s;
    s = {1'b0, v[2*W-1:W]} + {1'b0, v[W-1:0]};
    s = {1'b0, s[W-1:0]} + {{W{1'b0}}, s[W]};
    return (s[W-1:0] == P) ? '0 : s[W-1:0];
  endfunction

  // Operand a may be the non-canonical p; b is canonical, so one subtract always lands in [0, p-1].
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] canon(input logic [W-1:0] a);
    return (a == P) ? '0 : a;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first; any path that skipped an assignment would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = CALC;
          cnt_d   = CW'(1);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        issue = (cnt_q < CW'(STATE_SIZE));
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain cycles park the lane index at 1 so both operand reads stay inside x_r.
  assign lane   = issue ? cnt_q[LW-1:0] : LW'(1);
  assign x_prev = x_r[lane - LW'(1)];
  assign prod   = {{W{1'b0}}, x_prev} * {{W{1'b0}}, x_prev};

`ifdef MONOLITH_BRICKS_PIPE_EN
  logic           p_vld;
  logic [LW-1:0]  p_idx;
  logic [2*W-1:0] p_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld  <= 1'b0;
      p_idx  <= '0;
      p_prod <= '0;
    end else begin
      p_vld  <= issue;
      p_idx  <= lane;
      p_prod <= prod;
    end
  end

  assign wr_en   = p_vld;
  assign wr_idx  = p_idx;
  assign wr_prod = p_prod;
`else
  assign wr_en   = issue;
  assign wr_idx  = lane;
  assign wr_prod = prod;
`endif

  // x_r is frozen for the whole layer, so the addend read here matches the squared lane's neighbour.
  assign wr_cur = x_r[wr_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand copy and result array are cleared explicitly; an aborted layer must read as zero.
      for (int i = 0; i < STATE_SIZE; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else if (accept) begin
      x_r    <= bus.state_in;
      y_r[0] <= canon(bus.state_in[0]);
    end else if (wr_en) begin
      y_r[wr_idx] <= add_mod(wr_cur, mersenne_reduce(wr_prod));
    end
  end

  assign bus.state_out = y_r;
  assign bus.valid     = (state_q == DONE);
  assign bus.busy      = (state_q == CALC);

endmodule
